cdic_regs: RTL and testbench
============================

# cdic_regs

CD-i CD interface controller (CDIC) bus slave, mapped by the system address decoder into the 0x30xxxx window of the SCC68070 bus. It provides the 7680-word sector buffer RAM and the CDIC register file (command, time, file, channel, audio, buffer status, DMA, interrupt vector, data buffer) as word-wide, byte-lane-writable storage. It answers CPU cycles with a ready/ack handshake that the top-level bus mux forwards to the CPU.

## Interface
- No parameters.
- `clk` in 1: system clock (30 MHz domain).
- `reset` in 1: synchronous, active-high reset.
- `address` in 23 [23:1]: CPU word address; only [13:1] decoded, upper bits ignored (decoder qualifies via `cs`).
- `din` in 16: CPU write data.
- `dout` out 16: read data, valid whenever `bus_ack`=1 on a read.
- `uds` in 1: upper byte strobe, gates writes to [15:8].
- `lds` in 1: lower byte strobe, gates writes to [7:0].
- `write_strobe` in 1: 1 = write cycle, 0 = read cycle.
- `cs` in 1: chip select (address strobe already folded in), held for the whole CPU cycle.
- `bus_ack` out 1: cycle-complete acknowledge.

## Operation
- Byte offset `off` = {address[13:1],0}.
- 0x0000–0x3BFF: buffer RAM, 7680 x 16, single-port synchronous read. Contents not affected by reset.
- Registers (16-bit, reset 0):
  - 0x3C00 CMD
  - 0x3C02 TIME_HI, 0x3C04 TIME_LO
  - 0x3C06 FILE
  - 0x3C08 CHAN_HI, 0x3C0A CHAN_LO
  - 0x3C0C ACHAN
  - 0x3FF4 ABUF
  - 0x3FF6 XBUF
  - 0x3FF8 DMACTL
  - 0x3FFA AUDCTL
  - 0x3FFC IVEC
  - 0x3FFE DBUF
- Unmapped offsets (0x3C0E–0x3FF3): read 0x0000, writes ignored, still acknowledged.
- Writes: when `cs`&&`write_strobe`, `uds`=1 writes din[15:8] into the addressed word's [15:8]; `lds`=1 writes din[7:0] into [7:0]. Neither set: no change, still acked. Writes apply every cycle the condition holds; repeats are idempotent.
- Reads return the full 16-bit word regardless of `uds`/`lds`.
- ABUF and XBUF are read-to-clear on bit 15: the value returned is pre-clear; bit 15 clears in the same edge that captures `dout`, exactly once per read cycle.
- Read handshake FSM:
  - IDLE: `bus_ack`=0. On `cs`&&!`write_strobe`, latch the RAM/register value into `dout` and go to ACK.
  - ACK: `bus_ack`=1. Stay while `cs`=1; on `cs`=0 return to IDLE.
- Write handshake: `bus_ack`=1 combinationally whenever `cs`&&`write_strobe`, in any state.
- `cs`=0: `bus_ack`=0, `dout` holds its last value.

## Timing
- Reset: all registers 0, `dout`=0, FSM IDLE, `bus_ack`=0. Reset asserted mid-cycle aborts it; no write or read-clear occurs in the reset cycle.
- Read latency: `cs` rises at edge N, `bus_ack`=1 and `dout` valid from edge N+1. `bus_ack` holds until `cs` drops; it falls in the same cycle `cs` drops, then the FSM reaches IDLE.
- Write latency: zero-cycle ack; data stored at the first edge with `cs`&&`write_strobe`; reads see it from the next read cycle.
- Back-to-back reads need `cs` low for at least 1 cycle between them; a continuously held `cs` is a single access.
- Read and write never occur in the same cycle (`write_strobe` selects exactly one).

## Test plan
- Reset -> `bus_ack`=0, `dout`=0; read of 0x3C00 and 0x3FFE -> 0x0000.
- Word write 0x1234 at offset 0x0010 (uds=lds=1), then read -> ack at cs+1 cycle, `dout`=0x1234; RAM at 0x3BFE behaves the same.
- Write 0xAAAA to CMD with both strobes, then 0x55xx with uds only -> read CMD = 0x55AA; then 0xxx11 with lds only -> 0x5511.
- Write 0x8001 to XBUF, read -> 0x8001; read again -> 0x0001; ABUF behaves identically and independently.
- Read of unmapped 0x3D00 -> 0x0000 with ack; write to it -> acked immediately, later read still 0x0000.
- Assert reset while a read sits in ACK -> `bus_ack` drops next cycle, registers 0; next read completes normally with 1-cycle latency.

Source files
------------

// File: rtl/cdic_regs.sv
// rtl/cdic_regs.sv - CD-i CDIC bus slave: sector buffer RAM plus register file
// Word-wide, byte-lane-writable storage with a registered read handshake.
module cdic_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:1] address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic        cs,
    output logic        bus_ack
);

    localparam int RAM_WORDS = 7680;
    localparam int NUM_REGS  = 13;
    localparam logic [3:0] SEL_ABUF = 4'd7;
    localparam logic [3:0] SEL_XBUF = 4'd8;

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t      state_q;
    logic [15:0] dout_q;
    logic [15:0] mem [0:RAM_WORDS-1];
    logic [15:0] regs_q [NUM_REGS];

    logic [12:0] waddr;
    logic        ram_hit;
    logic        reg_hit;
    logic [3:0]  reg_sel;
    logic        wr_en;
    logic        rd_start;
    logic [15:0] reg_rdata;

    assign waddr    = address[13:1];
    assign ram_hit  = (waddr < 13'd7680);
    assign wr_en    = cs && write_strobe && !reset;
    assign rd_start = cs && !write_strobe && (state_q == S_IDLE);

    // Low block CMD..ACHAN occupies slots 0-6, high block ABUF..DBUF slots 7-12.
    always_comb begin
        reg_hit = 1'b0;
        reg_sel = 4'd0;
        if (waddr >= 13'h1E00 && waddr <= 13'h1E06) begin
            reg_hit = 1'b1;
            reg_sel = {1'b0, waddr[2:0]};
        end else if (waddr >= 13'h1FFA) begin
            reg_hit = 1'b1;
            reg_sel = 4'd5 + {1'b0, waddr[2:0]};
        end
    end

    assign reg_rdata = reg_hit ? regs_q[reg_sel] : 16'h0000;

    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            if (uds) mem[waddr][15:8] <= din[15:8];
            if (lds) mem[waddr][7:0]  <= din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0000;
        end else begin
            if (wr_en && reg_hit) begin
                if (uds) regs_q[reg_sel][15:8] <= din[15:8];
                if (lds) regs_q[reg_sel][7:0]  <= din[7:0];
            end
            // Status bit 15 clears on the same edge that captures the pre-clear value.
            if (rd_start && reg_hit && (reg_sel == SEL_ABUF || reg_sel == SEL_XBUF))
                regs_q[reg_sel][15] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dout_q  <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs && !write_strobe) begin
                        dout_q  <= ram_hit ? mem[waddr] : reg_rdata;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!cs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout    = dout_q;
    assign bus_ack = cs && (write_strobe || (state_q == S_ACK));

endmodule

// File: tb/tb_cdic_regs.sv
// tb/tb_cdic_regs.sv - directed self-checking bench for cdic_regs
module tb_cdic_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:1] address;
    logic [15:0] din;
    logic [15:0] dout;
    logic        uds, lds, write_strobe, cs;
    logic        bus_ack;

    int n_tests = 0;
    int n_fail  = 0;

    cdic_regs dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .din          (din),
        .dout         (dout),
        .uds          (uds),
        .lds          (lds),
        .write_strobe (write_strobe),
        .cs           (cs),
        .bus_ack      (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] off, input logic [15:0] data,
                             input logic u, input logic l, input string tag);
        address      = 23'(off >> 1);
        din          = data;
        uds          = u;
        lds          = l;
        write_strobe = 1'b1;
        cs           = 1'b1;
        #1;
        check({tag, "_wack"}, {15'd0, bus_ack}, 16'h0001);
        @(posedge clk);
        #1;
        cs           = 1'b0;
        write_strobe = 1'b0;
        uds          = 1'b0;
        lds          = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] off, input logic [15:0] exp, input string tag);
        address      = 23'(off >> 1);
        write_strobe = 1'b0;
        cs           = 1'b1;
        #1;
        check({tag, "_ack0"}, {15'd0, bus_ack}, 16'h0000);
        @(posedge clk);
        #1;
        check({tag, "_ack1"}, {15'd0, bus_ack}, 16'h0001);
        check({tag, "_data"}, dout, exp);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {15'd0, bus_ack}, 16'h0001);
        cs = 1'b0;
        #1;
        check({tag, "_drop"}, {15'd0, bus_ack}, 16'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; address = '0; din = '0;
        uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; cs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {15'd0, bus_ack}, 16'h0000);
        check("rst_dout", dout, 16'h0000);
        reset = 1'b0;

        bus_read(16'h3C00, 16'h0000, "rst_cmd");
        bus_read(16'h3FFE, 16'h0000, "rst_dbuf");

        bus_write(16'h0010, 16'h1234, 1'b1, 1'b1, "ram10");
        bus_read (16'h0010, 16'h1234, "ram10");
        bus_write(16'h3BFE, 16'hBEEF, 1'b1, 1'b1, "ramtop");
        bus_read (16'h3BFE, 16'hBEEF, "ramtop");
        bus_read (16'h0010, 16'h1234, "ram10b");

        bus_write(16'h3C00, 16'hAAAA, 1'b1, 1'b1, "cmd_w");
        bus_write(16'h3C00, 16'h55FF, 1'b1, 1'b0, "cmd_u");
        bus_read (16'h3C00, 16'h55AA, "cmd_u");
        bus_write(16'h3C00, 16'hFF11, 1'b0, 1'b1, "cmd_l");
        bus_read (16'h3C00, 16'h5511, "cmd_l");
        bus_write(16'h3C00, 16'hFFFF, 1'b0, 1'b0, "cmd_n");
        bus_read (16'h3C00, 16'h5511, "cmd_n");

        bus_write(16'h3C04, 16'h0C04, 1'b1, 1'b1, "tlo");
        bus_write(16'h3FFE, 16'hD00D, 1'b1, 1'b1, "dbuf");
        bus_read (16'h3C04, 16'h0C04, "tlo");
        bus_read (16'h3FFE, 16'hD00D, "dbuf");

        bus_write(16'h3FF6, 16'h8001, 1'b1, 1'b1, "xbuf");
        bus_write(16'h3FF4, 16'h8002, 1'b1, 1'b1, "abuf");
        bus_read (16'h3FF6, 16'h8001, "xbuf_r1");
        bus_read (16'h3FF6, 16'h0001, "xbuf_r2");
        bus_read (16'h3FF4, 16'h8002, "abuf_r1");
        bus_read (16'h3FF4, 16'h0002, "abuf_r2");
        bus_read (16'h3FF6, 16'h0001, "xbuf_r3");

        bus_read (16'h3D00, 16'h0000, "unm_r1");
        bus_write(16'h3D00, 16'hFFFF, 1'b1, 1'b1, "unm");
        bus_read (16'h3D00, 16'h0000, "unm_r2");

        bus_write(16'h3FF6, 16'h8003, 1'b1, 1'b1, "xbuf_pre");
        address      = 23'(16'h3C00 >> 1);
        write_strobe = 1'b0;
        cs           = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ack", {15'd0, bus_ack}, 16'h0001);
        check("mid_data", dout, 16'h5511);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ack", {15'd0, bus_ack}, 16'h0000);
        check("mid_rst_dout", dout, 16'h0000);
        cs    = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus_read(16'h3C00, 16'h0000, "post_cmd");
        bus_read(16'h3FF6, 16'h0000, "post_xbuf");
        bus_read(16'h0010, 16'h1234, "post_ram");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
